// File: rtl/scan_selector_if.sv
// Bus bundle for scan_selector: channel data and pointer controls in, selected data and index out.
// The WRAP flag exists only when SCAN_SELECTOR_WRAP_FLAG_EN is defined.
interface scan_selector_if #(
  parameter int bitWidth = 4,
  parameter int channels = 4
);
  localparam int selWidth = $clog2(channels);

  logic [channels*bitWidth-1:0] D;
  logic [selWidth-1:0]          SEL;
  logic                         LOAD;
  logic                         MODE;
  logic                         STEP;
  logic [bitWidth-1:0]          Y;
  logic [selWidth-1:0]          CH;

`ifdef SCAN_SELECTOR_WRAP_FLAG_EN
  logic                         WRAP;

  modport master (output D, SEL, LOAD, MODE, STEP, input Y, CH, WRAP);
  modport slave  (input D, SEL, LOAD, MODE, STEP, output Y, CH, WRAP);
`else
  modport master (output D, SEL, LOAD, MODE, STEP, input Y, CH);
  modport slave  (input D, SEL, LOAD, MODE, STEP, output Y, CH);
`endif
endinterface

// File: rtl/scan_selector.sv
// Registered N-channel selector with a loadable / auto-stepping channel pointer.
// Optional WRAP pulse output enabled by macro SCAN_SELECTOR_WRAP_FLAG_EN.
module scan_selector #(
  parameter int bitWidth = 4,
  parameter int channels = 4
) (
  input logic           CLK,
  input logic           N_RST,
  scan_selector_if.slave bus
);
  localparam int selWidth = $clog2(channels);
  localparam logic [selWidth-1:0] LAST_CH = selWidth'(channels - 1);

  logic [selWidth-1:0] ptr;
  logic [selWidth-1:0] next_ptr;
  logic [bitWidth-1:0] y_p1;
  logic                step_ok;

  assign step_ok = bus.MODE && bus.STEP;

  // LOAD outranks STEP; an out-of-range SEL clamps to the last channel
  always_comb begin
    next_ptr = ptr;
    if (bus.LOAD) begin
      if (int'(bus.SEL) >= channels) next_ptr = LAST_CH;
      else                           next_ptr = bus.SEL;
    end else if (step_ok) begin
      if (ptr == LAST_CH) next_ptr = '0;
      else                next_ptr = ptr + 1'b1;
    end
  end

  // p1: pointer and selected data registered together
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      ptr  <= '0;
      y_p1 <= '0;
    end else begin
      ptr  <= next_ptr;
      y_p1 <= bus.D[int'(next_ptr)*bitWidth +: bitWidth];
    end
  end

  assign bus.Y  = y_p1;
  assign bus.CH = ptr;

`ifdef SCAN_SELECTOR_WRAP_FLAG_EN
  logic wrap_p1;

  // only a STEP off the last channel counts as a wrap, never a LOAD to 0
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) wrap_p1 <= 1'b0;
    else        wrap_p1 <= !bus.LOAD && step_ok && (ptr == LAST_CH);
  end

  assign bus.WRAP = wrap_p1;
`endif
endmodule

// File: tb/tb_scan_selector.sv
// Directed bench for scan_selector: a 4-channel instance and a 3-channel instance for clamping.
module tb_scan_selector;
  logic CLK;
  logic N_RST;
  int   passed;
  int   total;

  scan_selector_if #(.bitWidth(4), .channels(4)) b4 ();
  scan_selector_if #(.bitWidth(4), .channels(3)) b3 ();

  scan_selector #(.bitWidth(4), .channels(4)) u4 (.CLK(CLK), .N_RST(N_RST), .bus(b4));
  scan_selector #(.bitWidth(4), .channels(3)) u3 (.CLK(CLK), .N_RST(N_RST), .bus(b3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    N_RST = 1'b0;
    b4.D = 16'h9753; b4.SEL = 2'd0; b4.LOAD = 1'b0; b4.MODE = 1'b0; b4.STEP = 1'b0;
    b3.D = 12'h753;  b3.SEL = 2'd0; b3.LOAD = 1'b0; b3.MODE = 1'b0; b3.STEP = 1'b0;
    #2;
    total++;
    if (b4.Y !== 4'd0 || b4.CH !== 2'd0)
      $display("FAIL reset_hold: Y=%0d CH=%0d, required Y=0 CH=0", b4.Y, b4.CH);
    else passed++;
    b4.LOAD = 1'b1; b4.SEL = 2'd2; b4.MODE = 1'b1; b4.STEP = 1'b1;
    tick();
    total++;
    if (b4.Y !== 4'd0 || b4.CH !== 2'd0)
      $display("FAIL reset_load_lost: Y=%0d CH=%0d, required Y=0 CH=0", b4.Y, b4.CH);
    else passed++;
    b4.LOAD = 1'b0; b4.SEL = 2'd0; b4.MODE = 1'b0; b4.STEP = 1'b0;
    #2 N_RST = 1'b1;
    tick();
    total++;
    if (b4.Y !== 4'd3 || b4.CH !== 2'd0)
      $display("FAIL reset_release: Y=%0d CH=%0d, required Y=3 CH=0", b4.Y, b4.CH);
    else passed++;
`ifdef SCAN_SELECTOR_WRAP_FLAG_EN
    total++;
    if (b4.WRAP !== 1'b0) $display("FAIL reset_wrap: WRAP=%0b, required 0", b4.WRAP);
    else passed++;
`endif
  endtask

  task automatic test_load();
    b4.LOAD = 1'b1; b4.SEL = 2'd2;
    tick();
    b4.LOAD = 1'b0; b4.SEL = 2'd0;
    total++;
    if (b4.Y !== 4'd7 || b4.CH !== 2'd2)
      $display("FAIL load_sel2: Y=%0d CH=%0d, required Y=7 CH=2", b4.Y, b4.CH);
    else passed++;
    b4.D = 16'h9453;
    tick();
    total++;
    if (b4.Y !== 4'd4 || b4.CH !== 2'd2)
      $display("FAIL load_track_d: Y=%0d CH=%0d, required Y=4 CH=2", b4.Y, b4.CH);
    else passed++;
    b4.D = 16'h9753;
    tick();
    total++;
    if (b4.Y !== 4'd7) $display("FAIL load_track_back: Y=%0d, required 7", b4.Y);
    else passed++;
  endtask

  task automatic test_scan();
    logic [1:0] exp_ch [5];
    logic [3:0] exp_y  [5];
    exp_ch = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_y  = '{4'd5, 4'd7, 4'd9, 4'd3, 4'd5};
    b4.LOAD = 1'b1; b4.SEL = 2'd0;
    tick();
    b4.LOAD = 1'b0;
    b4.MODE = 1'b1; b4.STEP = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (b4.CH !== exp_ch[i] || b4.Y !== exp_y[i])
        $display("FAIL scan_edge%0d: CH=%0d Y=%0d, required CH=%0d Y=%0d",
                 i + 1, b4.CH, b4.Y, exp_ch[i], exp_y[i]);
      else passed++;
`ifdef SCAN_SELECTOR_WRAP_FLAG_EN
      total++;
      if (b4.WRAP !== (i == 3))
        $display("FAIL scan_wrap%0d: WRAP=%0b, required %0b", i + 1, b4.WRAP, (i == 3));
      else passed++;
`endif
    end
    b4.STEP = 1'b0;
    b4.LOAD = 1'b1; b4.SEL = 2'd3;
    tick();
    b4.SEL = 2'd0;
    tick();
    b4.LOAD = 1'b0;
    total++;
    if (b4.CH !== 2'd0 || b4.Y !== 4'd3)
      $display("FAIL load_zero: CH=%0d Y=%0d, required CH=0 Y=3", b4.CH, b4.Y);
    else passed++;
`ifdef SCAN_SELECTOR_WRAP_FLAG_EN
    total++;
    if (b4.WRAP !== 1'b0) $display("FAIL load_zero_wrap: WRAP=%0b, required 0", b4.WRAP);
    else passed++;
`endif
  endtask

  task automatic test_mode_priority();
    b4.LOAD = 1'b1; b4.SEL = 2'd2;
    tick();
    b4.LOAD = 1'b0;
    b4.MODE = 1'b0; b4.STEP = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (b4.CH !== 2'd2 || b4.Y !== 4'd7)
        $display("FAIL mode0_hold%0d: CH=%0d Y=%0d, required CH=2 Y=7", i + 1, b4.CH, b4.Y);
      else passed++;
    end
    b4.LOAD = 1'b1; b4.SEL = 2'd1; b4.MODE = 1'b1; b4.STEP = 1'b1;
    tick();
    total++;
    if (b4.CH !== 2'd1 || b4.Y !== 4'd5)
      $display("FAIL load_beats_step: CH=%0d Y=%0d, required CH=1 Y=5", b4.CH, b4.Y);
    else passed++;
    b4.LOAD = 1'b0; b4.STEP = 1'b0;
    tick();
    total++;
    if (b4.CH !== 2'd1) $display("FAIL step_not_deferred: CH=%0d, required 1", b4.CH);
    else passed++;
    b4.MODE = 1'b0;
  endtask

  task automatic test_clamp();
    b3.LOAD = 1'b1; b3.SEL = 2'd3;
    tick();
    b3.LOAD = 1'b0; b3.SEL = 2'd0;
    total++;
    if (b3.CH !== 2'd2 || b3.Y !== 4'd7)
      $display("FAIL clamp_sel3: CH=%0d Y=%0d, required CH=2 Y=7", b3.CH, b3.Y);
    else passed++;
    b3.MODE = 1'b1; b3.STEP = 1'b1;
    tick();
    b3.STEP = 1'b0;
    total++;
    if (b3.CH !== 2'd0 || b3.Y !== 4'd3)
      $display("FAIL clamp_wrap3: CH=%0d Y=%0d, required CH=0 Y=3", b3.CH, b3.Y);
    else passed++;
  endtask

  task automatic test_reset_mid_scan();
    b4.LOAD = 1'b1; b4.SEL = 2'd3;
    tick();
    b4.LOAD = 1'b0;
    total++;
    if (b4.CH !== 2'd3 || b4.Y !== 4'd9)
      $display("FAIL pre_reset_ch3: CH=%0d Y=%0d, required CH=3 Y=9", b4.CH, b4.Y);
    else passed++;
    #2 N_RST = 1'b0;
    #1;
    total++;
    if (b4.Y !== 4'd0 || b4.CH !== 2'd0)
      $display("FAIL async_reset: Y=%0d CH=%0d, required Y=0 CH=0", b4.Y, b4.CH);
    else passed++;
    #1 N_RST = 1'b1;
    b4.MODE = 1'b1; b4.STEP = 1'b1;
    tick();
    b4.STEP = 1'b0;
    total++;
    if (b4.CH !== 2'd1 || b4.Y !== 4'd5)
      $display("FAIL restart_scan: CH=%0d Y=%0d, required CH=1 Y=5", b4.CH, b4.Y);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_load();
    test_scan();
    test_mode_priority();
    test_clamp();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
